// File: rtl/mmtrg_frame_parser_if.sv
// Framed-stream handshake bundle: DIN/iVALID/oREADY into the parser, DOUT/oVALID/iREADY out of it.
// master drives the frame words and accepts samples; slave is the parser.
interface mmtrg_frame_parser_if #(
   parameter int DIN_WIDTH = 64
);
   logic [DIN_WIDTH-1:0] DIN;
   logic                 iVALID;
   logic                 oREADY;
   logic [DIN_WIDTH-1:0] DOUT;
   logic                 oVALID;
   logic                 iREADY;

   modport master (
      output DIN, iVALID, iREADY,
      input  oREADY, DOUT, oVALID
   );

   modport slave (
      input  DIN, iVALID, iREADY,
      output oREADY, DOUT, oVALID
   );
endinterface

// File: rtl/mmtrg_frame_parser.sv
// Frame parser: strips header/footer, forwards sample words, reports frame metadata and framing errors.
// Latency: data word accepted at N -> DOUT/oVALID at N+1; footer at N -> FRAME_DONE at N+1.
// Backpressure: single-entry output register, oREADY = !oVALID | iREADY in DATA; optional MMTRG_FRAME_PARSER_CH_FILTER_EN.
module mmtrg_frame_parser #(
   parameter int CHANNEL_ID             = 0,
   parameter int MAX_FRAME_LENGTH       = 200,
   parameter int TIME_STAMP_WIDTH       = 48,
   parameter int FIRST_TIME_STAMP_WIDTH = 24,
   parameter int DIN_WIDTH              = 64
) (
   input  logic                        CLK,
   input  logic                        RESETN,
   mmtrg_frame_parser_if.slave         bus,
   output logic                        FRAME_DONE,
   output logic [7:0]                  FRAME_CH,
   output logic [TIME_STAMP_WIDTH-1:0] FRAME_TIME,
   output logic [11:0]                 FRAME_LEN,
   output logic                        ERR_HEADER,
   output logic                        ERR_OVERFLOW,
   output logic                        ERR_LENGTH
);

   typedef enum logic [1:0] {IDLE, DATA, DONE} state_e;

   localparam logic [11:0] MAX_LEN = 12'(MAX_FRAME_LENGTH);

   state_e                            state_q, state_d;
   logic [11:0]                       cnt_q, cnt_d;
   logic [7:0]                        ch_q, ch_d;
   logic [FIRST_TIME_STAMP_WIDTH-1:0] ts_lo_q, ts_lo_d;
   logic                              drop_q, drop_d;
   logic [DIN_WIDTH-1:0]              dout_q, dout_d;
   logic                              ovld_q, ovld_d;
   logic                              done_q, done_d;
   logic [7:0]                        fch_q, fch_d;
   logic [TIME_STAMP_WIDTH-1:0]       ftime_q, ftime_d;
   logic [11:0]                       flen_q, flen_d;
   logic                              errh_q, errh_d;
   logic                              erro_q, erro_d;
   logic                              errl_q, errl_d;

   logic rdy, acc, is_hdr, is_ftr, hdr_drop;

   assign is_hdr = (bus.DIN[63:56] == 8'hAA);
   assign is_ftr = (bus.DIN[63:56] == 8'h55);

`ifdef MMTRG_FRAME_PARSER_CH_FILTER_EN
   assign hdr_drop = (bus.DIN[55:48] != 8'(CHANNEL_ID));
`else
   assign hdr_drop = 1'b0;
`endif

   always_comb begin
      rdy = 1'b0;
      unique case (state_q)
         IDLE:    rdy = 1'b1;
         DATA:    rdy = !ovld_q || bus.iREADY;
         default: rdy = 1'b0;
      endcase
   end

   // Held low while in reset so nothing is accepted before the FSM is initialised.
   assign bus.oREADY = RESETN && rdy;
   assign acc        = bus.iVALID && bus.oREADY;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ch_d    = ch_q;
      ts_lo_d = ts_lo_q;
      drop_d  = drop_q;
      dout_d  = dout_q;
      ovld_d  = ovld_q && !bus.iREADY;
      done_d  = 1'b0;
      fch_d   = fch_q;
      ftime_d = ftime_q;
      flen_d  = flen_q;
      errh_d  = 1'b0;
      erro_d  = 1'b0;
      errl_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (acc && !is_hdr) errh_d = 1'b1;
         end
         DATA: begin
            if (acc) begin
               if (is_hdr) begin
                  errl_d = 1'b1;
               end else if (is_ftr) begin
                  state_d = DONE;
                  errl_d  = (bus.DIN[31:20] != cnt_q);
                  if (!drop_q) begin
                     done_d  = 1'b1;
                     fch_d   = ch_q;
                     ftime_d = {bus.DIN[55:32], ts_lo_q};
                     flen_d  = cnt_q;
                  end
               end else if (cnt_q == MAX_LEN) begin
                  // Checked before incrementing so the count can never wrap.
                  erro_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + 12'd1;
                  if (!drop_q) begin
                     dout_d = bus.DIN;
                     ovld_d = 1'b1;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // A header in IDLE or mid-frame always (re)starts a frame.
      if (acc && is_hdr && (state_q != DONE)) begin
         state_d = DATA;
         cnt_d   = 12'd0;
         ch_d    = bus.DIN[55:48];
         ts_lo_d = bus.DIN[47:24];
         drop_d  = hdr_drop;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ch_q    <= '0;
         ts_lo_q <= '0;
         drop_q  <= 1'b0;
         dout_q  <= '0;
         ovld_q  <= 1'b0;
         done_q  <= 1'b0;
         fch_q   <= '0;
         ftime_q <= '0;
         flen_q  <= '0;
         errh_q  <= 1'b0;
         erro_q  <= 1'b0;
         errl_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ch_q    <= ch_d;
         ts_lo_q <= ts_lo_d;
         drop_q  <= drop_d;
         dout_q  <= dout_d;
         ovld_q  <= ovld_d;
         done_q  <= done_d;
         fch_q   <= fch_d;
         ftime_q <= ftime_d;
         flen_q  <= flen_d;
         errh_q  <= errh_d;
         erro_q  <= erro_d;
         errl_q  <= errl_d;
      end
   end

   assign bus.DOUT   = dout_q;
   assign bus.oVALID = ovld_q;
   assign FRAME_DONE   = done_q;
   assign FRAME_CH     = fch_q;
   assign FRAME_TIME   = ftime_q;
   assign FRAME_LEN    = flen_q;
   assign ERR_HEADER   = errh_q;
   assign ERR_OVERFLOW = erro_q;
   assign ERR_LENGTH   = errl_q;

endmodule
